// File: rtl/sap_ram_ctrl.sv
// SAP RAM controller: MAR, DEPTH x DATA_WIDTH array, active-low bus strobes,
// front-panel program mode with edge-detected write, and a post-reset clear sequencer.
module sap_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mar_in_n,
    input  logic                  ram_in_n,
    input  logic                  ram_out_n,
    input  logic                  prog_mode,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic                  prog_we,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_drive,
    output logic [ADDR_WIDTH-1:0] mar_q,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] w_clr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_mar;
    logic [ADDR_WIDTH-1:0] w_mar_nxt;
    logic                  r_we_hist;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_prog_press;

    // History is sampled unconditionally, so a button held across reset,
    // clear or a mode switch never looks like a fresh press.
    assign w_prog_press = prog_we & ~r_we_hist;
    assign mar_q        = r_mar;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_mar     <= '0;
            r_we_hist <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_mar     <= w_mar_nxt;
            r_we_hist <= prog_we;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_mar_nxt     = r_mar;
        w_mem_we      = 1'b0;
        w_mem_addr    = r_mar;
        w_mem_wdata   = bus_in;
        bus_out       = '0;
        bus_drive     = 1'b0;
        init_busy     = 1'b0;

        case (r_state)
            S_CLEAR: begin
                init_busy     = 1'b1;
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_ptr;
                w_mem_wdata   = '0;
                w_clr_ptr_nxt = r_clr_ptr + ADDR_WIDTH'(1);
                if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (prog_mode) begin
                    w_mar_nxt = prog_addr;
                    if (w_prog_press) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = prog_addr;
                        w_mem_wdata = prog_data;
                    end
                end else begin
                    if (!mar_in_n) begin
                        w_mar_nxt = bus_in[ADDR_WIDTH-1:0];
                    end
                    // Write uses the MAR value from before this edge's load.
                    if (!ram_in_n) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_mar;
                        w_mem_wdata = bus_in;
                    end
                    if (!ram_out_n && ram_in_n) begin
                        bus_drive = 1'b1;
                        bus_out   = r_mem[r_mar];
                    end
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase

        if (reset) begin
            w_mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_sap_ram_ctrl.sv
// Bench for sap_ram_ctrl: directed scenarios plus randomized traffic against a word-level model.
module tb_sap_ram_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mar_in_n, ram_in_n, ram_out_n;
    logic       prog_mode, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data, bus_in;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [3:0] mar_q;
    logic       init_busy;

    int tests = 0;
    int fails = 0;

    // Reference model: memory words, MAR, button history, cycles of clear left.
    logic [7:0] m_mem [16];
    int         m_mar;
    logic       m_hist;
    int         m_clear_left;

    sap_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .mar_in_n(mar_in_n), .ram_in_n(ram_in_n),
        .ram_out_n(ram_out_n), .prog_mode(prog_mode), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_we(prog_we), .bus_in(bus_in),
        .bus_out(bus_out), .bus_drive(bus_drive), .mar_q(mar_q), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_clear_left = 16;
            m_mar        = 0;
            m_hist       = 1'b0;
        end else begin
            if (m_clear_left > 0) begin
                m_mem[16 - m_clear_left] = 8'h00;
                m_clear_left--;
            end else if (prog_mode) begin
                if (prog_we && !m_hist) m_mem[prog_addr] = prog_data;
                m_mar = prog_addr;
            end else begin
                if (!ram_in_n) m_mem[m_mar] = bus_in;
                if (!mar_in_n) m_mar = bus_in % 16;
            end
            m_hist = prog_we;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic       busy_e, drv_e;
        logic [7:0] out_e;
        busy_e = (m_clear_left > 0);
        drv_e  = !busy_e && !prog_mode && !ram_out_n && ram_in_n;
        out_e  = drv_e ? m_mem[m_mar] : 8'h00;
        chk({tag, ".mar"}, 32'(mar_q), 32'(m_mar));
        chk({tag, ".busy"}, 32'(init_busy), 32'(busy_e));
        chk({tag, ".drive"}, 32'(bus_drive), 32'(drv_e));
        chk({tag, ".out"}, 32'(bus_out), 32'(out_e));
    endtask

    task automatic idle_inputs();
        mar_in_n = 1; ram_in_n = 1; ram_out_n = 1;
        prog_mode = 0; prog_we = 0; prog_addr = 0; prog_data = 0; bus_in = 0;
    endtask

    task automatic load_mar(input logic [7:0] v);
        prog_mode = 0; mar_in_n = 0; ram_in_n = 1; ram_out_n = 1; bus_in = v;
        tick();
        mar_in_n = 1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        load_mar({4'h0, a});
        ram_in_n = 0; bus_in = d;
        tick();
        ram_in_n = 1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        load_mar({4'h0, a});
        ram_out_n = 0;
        #1;
        check_model("rd");
        chk("rd.drive1", 32'(bus_drive), 32'd1);
        d = bus_out;
        ram_out_n = 1;
    endtask

    // Counts cycles with init_busy high while random strobes are applied.
    task automatic run_clear(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            chk("clr.drive", 32'(bus_drive), 32'd0);
            chk("clr.mar", 32'(mar_q), 32'd0);
            {mar_in_n, ram_in_n, ram_out_n, prog_mode, prog_we} = 5'($urandom);
            prog_addr = 4'($urandom); prog_data = 8'($urandom); bus_in = 8'($urandom);
            tick();
            n++;
        end
        idle_inputs();
        #1;
    endtask

    initial begin
        int         n;
        logic [7:0] d, keep7;

        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        chk("rst.mar", 32'(mar_q), 32'd0);
        chk("rst.out", 32'(bus_out), 32'd0);
        chk("rst.drive", 32'(bus_drive), 32'd0);
        chk("rst.busy", 32'(init_busy), 32'd1);

        // 1: clear length and zeroed array
        run_clear(n);
        chk("clr.len", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            chk("clr.zero", 32'(d), 32'h00);
        end

        // 2: basic run-mode writes and reads
        load_mar(8'h02); ram_in_n = 0; bus_in = 8'hAA; tick(); ram_in_n = 1;
        load_mar(8'h05); ram_in_n = 0; bus_in = 8'hCC; tick(); ram_in_n = 1;
        rd(4'h2, d); chk("run.r2", 32'(d), 32'hAA);
        rd(4'h5, d); chk("run.r5", 32'(d), 32'hCC);
        ram_out_n = 1; #1;
        chk("run.idle_out", 32'(bus_out), 32'h00);
        chk("run.idle_drv", 32'(bus_drive), 32'd0);

        // 3: MAR load and write on the same edge; write with read strobe
        keep7 = m_mem[7];
        load_mar(8'h03);
        bus_in = 8'h07; mar_in_n = 0; ram_in_n = 0;
        tick();
        mar_in_n = 1; ram_in_n = 1;
        chk("sim.mar", 32'(mar_q), 32'h7);
        rd(4'h3, d); chk("sim.m3", 32'(d), 32'h07);
        rd(4'h7, d); chk("sim.m7", 32'(d), 32'(keep7));
        ram_in_n = 0; ram_out_n = 0; bus_in = 8'h3C; #1;
        chk("rw.drive", 32'(bus_drive), 32'd0);
        chk("rw.out", 32'(bus_out), 32'h00);
        tick();
        ram_in_n = 1; ram_out_n = 1;
        rd(4'h7, d); chk("rw.m7", 32'(d), 32'h3C);

        // 4: program mode, one write per press
        prog_mode = 1; prog_addr = 4'h9; prog_data = 8'h5A; prog_we = 0; ram_out_n = 0;
        tick();
        check_model("prog.pre");
        chk("prog.mar", 32'(mar_q), 32'h9);
        chk("prog.drive", 32'(bus_drive), 32'd0);
        prog_we = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) prog_data = 8'h11;
            tick();
            check_model("prog.hold");
        end
        prog_we = 0; ram_out_n = 1;
        tick();
        prog_mode = 0;
        chk("prog.mar_keep", 32'(mar_q), 32'h9);
        rd(4'h9, d); chk("prog.m9", 32'(d), 32'h5A);

        // 5: address wrap, and button held across a mode switch
        load_mar(8'h1F);
        chk("wrap.mar", 32'(mar_q), 32'hF);
        wr(4'h4, 8'h44);
        prog_we = 1; tick(); tick();
        prog_mode = 1; prog_addr = 4'h4; prog_data = 8'hEE;
        tick(); tick(); tick();
        prog_we = 0; tick();
        prog_mode = 0;
        rd(4'h4, d); chk("guard.m4", 32'(d), 32'h44);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) prog_mode = ~prog_mode;
            {mar_in_n, ram_in_n, ram_out_n, prog_we} = 4'($urandom);
            prog_addr = 4'($urandom); prog_data = 8'($urandom); bus_in = 8'($urandom);
            #1;
            check_model("rnd");
            tick();
        end
        idle_inputs();
        #1;
        check_model("rnd.end");

        // 6: reset with data loaded, then again mid-clear
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("mid.busy", 32'(init_busy), 32'd1);
        reset = 1; tick(); reset = 0;
        chk("mid.mar", 32'(mar_q), 32'd0);
        run_clear(n);
        chk("mid.len", 32'(n), 32'd16);
        chk("mid.mar_after", 32'(mar_q), 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            chk("mid.zero", 32'(d), 32'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sap_ram_ctrl.md
Name: sap_ram_ctrl

Overview:
- Parametrised successor to the 16x8 SAP RAM.
- Combines the memory address register (MAR), a DEPTH x DATA_WIDTH storage array, active-low bus control strobes, and a front-panel program mode with edge-detected manual write.
- After reset, a clear sequencer zeroes the array before the block accepts bus traffic.
- Sits on the shared 8-bit system bus between the controller sequencer and the top-level bus mux.

Parameters:
DATA_WIDTH, 8, word width of the array and the bus.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
mar_in_n  input  1  active-low; load MAR from bus_in[ADDR_WIDTH-1:0].
ram_in_n  input  1  active-low; write bus_in to mem[MAR].
ram_out_n  input  1  active-low; drive mem[MAR] onto bus_out.
prog_mode  input  1  1 = front-panel program mode, 0 = run mode.
prog_addr  input  ADDR_WIDTH  front-panel address switches.
prog_data  input  DATA_WIDTH  front-panel data switches.
prog_we  input  1  front-panel write button, level; rising edge is the event.
bus_in  input  DATA_WIDTH  system bus value.
bus_out  output  DATA_WIDTH  read data; 0 when not driving.
bus_drive  output  1  1 when bus_out must be placed on the bus by the top-level mux.
mar_q  output  ADDR_WIDTH  current MAR value, for LEDs.
init_busy  output  1  1 while the clear sequencer runs.

Behaviour:
- Reset (sync, active-high) values:
  - mar_q = 0, bus_out = 0, bus_drive = 0, init_busy = 1.
  - clear pointer = 0, prog_we history register = 0.
- Array contents are not reset directly; the clear sequencer zeroes them.
- Reset asserted mid-clear or mid-operation restarts the clear from address 0.
- Clear sequencer, states CLEAR -> IDLE:
  - CLEAR: each cycle writes 0 to mem[clr_ptr], then clr_ptr++.
  - On the cycle that writes DEPTH-1, the next state is IDLE and init_busy falls.
  - Clear takes exactly DEPTH cycles after reset deasserts (16 cycles at default).
  - During CLEAR, all strobes and prog inputs are ignored; bus_drive = 0 and mar_q holds 0.
- prog_we history register samples prog_we every cycle in every state and mode.
  - A button held through reset, clear or a mode switch produces no write.
- Run mode (prog_mode=0, IDLE):
  - mar_in_n low at edge: MAR <= bus_in[ADDR_WIDTH-1:0].
  - ram_in_n low at edge: mem[MAR] <= bus_in, using MAR before any same-edge update.
  - mar_in_n and ram_in_n both low: write goes to the old MAR, and MAR loads in the same edge.
  - Read is combinational from the registered MAR: when ram_out_n is low and ram_in_n is high, bus_out = mem[MAR] and bus_drive = 1, same cycle.
  - ram_out_n and ram_in_n both low: the write proceeds; bus_drive = 0 and bus_out = 0 (no self-loop).
  - Otherwise bus_out = 0 and bus_drive = 0.
- Program mode (prog_mode=1, IDLE):
  - MAR <= prog_addr every cycle.
  - mar_in_n, ram_in_n and ram_out_n are ignored; bus_drive = 0, bus_out = 0.
  - Rising edge of prog_we (prog_we=1 and history=0) at a clock edge: mem[prog_addr] <= prog_data. Exactly one write per press.
- Mode switch from program to run: MAR keeps the last prog_addr. No spurious write on either switch direction.
- Address wrap: MAR is ADDR_WIDTH bits; upper bus_in bits are discarded (bus 8'h1F with ADDR_WIDTH=4 loads MAR = 4'hF).
- Data path has no width conversion; bus_in and storage are both DATA_WIDTH.

Test Plan:
1. Reset 1 cycle, then release -> init_busy high for exactly 16 cycles then low; read of every address gives 8'h00; bus_drive=0 throughout the clear.
2. Run mode: bus_in=8'h02 with mar_in_n=0; bus_in=8'hAA with ram_in_n=0; then bus_in=8'h05 with mar_in_n=0; bus_in=8'hCC with ram_in_n=0 -> with ram_out_n=0 and MAR=2, bus_out=8'hAA, bus_drive=1; with MAR=5, bus_out=8'hCC; with ram_out_n=1, bus_out=0 and bus_drive=0.
3. Simultaneous events: MAR=3, bus_in=8'h07, mar_in_n=ram_in_n=0 for one edge -> mem[3]=8'h07, mem[7] unchanged, mar_q=7. Then ram_in_n=ram_out_n=0 -> bus_drive=0 and the write occurs.
4. Program mode: prog_addr=9, prog_data=8'h5A, prog_we held high 5 cycles -> exactly one write to mem[9]; change prog_data to 8'h11 while still held -> mem[9] stays 8'h5A; return to run mode and read 9 -> 8'h5A.
5. Wrap and edge guard: bus_in=8'h1F with mar_in_n=0 -> mar_q=4'hF. Separately, hold prog_we=1 while switching prog_mode 0->1 -> no write occurs.
6. Reset mid-clear at cycle 8, and reset after data is loaded -> clear restarts and takes 16 full cycles; all words read 0 afterwards; mar_q=0.
